// File: rtl/pipeline_pkg.sv
// Shared decode constants, types and helpers for the
// 5-stage 20-bit pipeline hazard logic.
package pipeline_pkg;

  localparam int INSTR_W = 20;
  localparam int NREGS   = 16;

  localparam int OPC_HI = 19;
  localparam int OPC_LO = 16;
  localparam int DST_HI = 15;
  localparam int DST_LO = 12;
  localparam int OP1_HI = 11;
  localparam int OP1_LO = 8;
  localparam int OP2_HI = 7;
  localparam int OP2_LO = 4;

  typedef logic [3:0] opcode_t;
  typedef logic [3:0] reg_t;

  localparam opcode_t OP_LD   = 4'h0;
  localparam opcode_t OP_ST   = 4'h1;
  localparam opcode_t OP_ALU0 = 4'h2;
  localparam opcode_t OP_ALU7 = 4'h9;
  localparam opcode_t OP_BEQ  = 4'hA;
  localparam opcode_t OP_BNE  = 4'hB;
  localparam opcode_t OP_J    = 4'hC;
  localparam opcode_t OP_NOP  = 4'hF;

  typedef enum logic {
    RUN,
    BR_PEND
  } state_t;

  function automatic logic is_alu(opcode_t op);
    return (op >= OP_ALU0) && (op <= OP_ALU7);
  endfunction

  function automatic logic writes_dest(opcode_t op);
    return !(op == OP_ST || op == OP_BEQ ||
             op == OP_BNE || op == OP_J ||
             op == OP_NOP);
  endfunction

  function automatic logic reads_op1(opcode_t op);
    return !(op == OP_J || op == OP_NOP);
  endfunction

  function automatic logic reads_op2(opcode_t op);
    return is_alu(op) || op == OP_ST ||
           op == OP_BEQ || op == OP_BNE;
  endfunction

  function automatic logic is_ctrl(opcode_t op);
    return op == OP_BEQ || op == OP_BNE ||
           op == OP_J;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// ID-stage view of the pipeline: instruction and branch
// status in, stall/flush controls out.
interface pipeline_hazard_controller_if;
  import pipeline_pkg::*;

  logic [INSTR_W-1:0] id_instruction;
  logic               id_valid;
  logic               ex_branch_resolved;
  logic               ex_branch_taken;
  logic               pc_write;
  logic               pc_sel;
  logic               if_id_write;
  logic               if_id_flush;
  logic               id_ex_bubble;
  logic               raw_stall;

  modport master (
    output id_instruction,
    output id_valid,
    output ex_branch_resolved,
    output ex_branch_taken,
    input  pc_write,
    input  pc_sel,
    input  if_id_write,
    input  if_id_flush,
    input  id_ex_bubble,
    input  raw_stall
  );

  modport slave (
    input  id_instruction,
    input  id_valid,
    input  ex_branch_resolved,
    input  ex_branch_taken,
    output pc_write,
    output pc_sel,
    output if_id_write,
    output if_id_flush,
    output id_ex_bubble,
    output raw_stall
  );

endinterface

// File: rtl/pipeline_hazard_controller_scoreboard.sv
// Per-register countdown of bubbles still owed before
// a consumer in ID may read that register.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int ALU_STALL  = 0,
  parameter int CNT_W      = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic id_valid,
  input  logic rd1,
  input  logic rd2,
  input  reg_t op1,
  input  reg_t op2,
  input  logic load_en,
  input  reg_t dest,
  input  logic is_load,
  output logic raw_stall
);

  localparam int CMAX = (1 << CNT_W) - 1;

  if (LOAD_STALL > CMAX) begin : g_load_range
    $error("LOAD_STALL does not fit in CNT_W");
  end
  if (ALU_STALL > CMAX) begin : g_alu_range
    $error("ALU_STALL does not fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] LD_V =
    CNT_W'(LOAD_STALL);
  localparam logic [CNT_W-1:0] AL_V =
    CNT_W'(ALU_STALL);

  logic [CNT_W-1:0] cnt [NREGS];

  // A fresh load wins over that entry's decay
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (load_en && dest == 4'(i))
          cnt[i] <= is_load ? LD_V : AL_V;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  assign raw_stall = id_valid &
    ((rd1 & (cnt[op1] != '0)) |
     (rd2 & (cnt[op2] != '0)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer beside ID: RAW interlock plus
// fetch hold while a branch is unresolved in EX.
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int ALU_STALL  = 0,
  parameter int CNT_W      = 2
) (
  input logic clock,
  input logic reset,
  pipeline_hazard_controller_if.slave bus
);

  opcode_t opc;
  reg_t    dst;
  reg_t    op1;
  reg_t    op2;

  assign opc = bus.id_instruction[OPC_HI:OPC_LO];
  assign dst = bus.id_instruction[DST_HI:DST_LO];
  assign op1 = bus.id_instruction[OP1_HI:OP1_LO];
  assign op2 = bus.id_instruction[OP2_HI:OP2_LO];

  state_t state;
  state_t state_nx;

  logic hz;
  logic issue;
  logic load_en;
  logic run_like;
  logic taken;
  logic hold;
  logic pc_write;
  logic pc_sel;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_bubble;
  logic raw_out;

  assign load_en = issue & writes_dest(opc);

  hazard_scoreboard #(
    .LOAD_STALL(LOAD_STALL),
    .ALU_STALL (ALU_STALL),
    .CNT_W     (CNT_W)
  ) u_sb (
    .clock    (clock),
    .reset    (reset),
    .id_valid (bus.id_valid),
    .rd1      (reads_op1(opc)),
    .rd2      (reads_op2(opc)),
    .op1      (op1),
    .op2      (op2),
    .load_en  (load_en),
    .dest     (dst),
    .is_load  (opc == OP_LD),
    .raw_stall(hz)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  // A not-taken resolve behaves as an ordinary RUN cycle
  assign taken = (state == BR_PEND) &
    bus.ex_branch_resolved & bus.ex_branch_taken;
  assign hold = (state == BR_PEND) &
    !bus.ex_branch_resolved;
  assign run_like = (state == RUN) |
    ((state == BR_PEND) & bus.ex_branch_resolved &
     !bus.ex_branch_taken);

  always_comb begin
    state_nx     = state;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    issue        = 1'b0;
    raw_out      = hz;
    if (reset) begin
      if_id_flush = 1'b1;
      raw_out     = 1'b0;
      state_nx    = RUN;
    end else begin
      unique case (1'b1)
        taken: begin
          pc_sel      = 1'b1;
          pc_write    = 1'b1;
          if_id_flush = 1'b1;
          state_nx    = RUN;
        end
        hold: begin
          state_nx = BR_PEND;
        end
        run_like && hz: begin
          state_nx = RUN;
        end
        run_like && !hz: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_bubble = !bus.id_valid;
          issue        = bus.id_valid;
          state_nx = (bus.id_valid && is_ctrl(opc))
                   ? BR_PEND : RUN;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.pc_sel       = pc_sel;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.raw_stall    = raw_out;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Three controllers with different stall settings share
// one stimulus stream; a ready-cycle model checks them.
module tb_pipeline_hazard_controller;
  import pipeline_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipeline_hazard_controller_if b0 ();
  pipeline_hazard_controller_if b1 ();
  pipeline_hazard_controller_if b2 ();

  pipeline_hazard_controller #(
    .LOAD_STALL(1), .ALU_STALL(0), .CNT_W(2)
  ) u0 (.clock(clock), .reset(reset), .bus(b0));
  pipeline_hazard_controller #(
    .LOAD_STALL(2), .ALU_STALL(2), .CNT_W(2)
  ) u1 (.clock(clock), .reset(reset), .bus(b1));
  pipeline_hazard_controller #(
    .LOAD_STALL(3), .ALU_STALL(1), .CNT_W(2)
  ) u2 (.clock(clock), .reset(reset), .bus(b2));

  int ls [3] = '{1, 2, 3};
  int as [3] = '{0, 2, 1};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ready[k][r]: first cycle register r may be read
  int ready  [3][16];
  int nready [3][16];
  bit pend   [3];
  bit npend  [3];

  logic [19:0] ins;
  logic        v, res, tk;
  bit          lit_en  [3];
  logic [5:0]  lit_val [3];

  function automatic logic [19:0] mk(
    int op, int d, int a, int b);
    logic [19:0] r;
    r = {4'(op), 4'(d), 4'(a), 4'(b), 4'h0};
    return r;
  endfunction

  // {pc_write,pc_sel,if_id_write,flush,bubble,raw}
  function automatic logic [5:0] got(int k);
    case (k)
      0: return {b0.pc_write, b0.pc_sel,
                 b0.if_id_write, b0.if_id_flush,
                 b0.id_ex_bubble, b0.raw_stall};
      1: return {b1.pc_write, b1.pc_sel,
                 b1.if_id_write, b1.if_id_flush,
                 b1.id_ex_bubble, b1.raw_stall};
      default:
         return {b2.pc_write, b2.pc_sel,
                 b2.if_id_write, b2.if_id_flush,
                 b2.id_ex_bubble, b2.raw_stall};
    endcase
  endfunction

  task automatic chk(string nm, logic [5:0] g,
                     logic [5:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%b want=%b cyc=%0d",
               nm, g, e, cyc);
    end
  endtask

  task automatic lit(int k, logic [5:0] val);
    lit_en[k]  = 1'b1;
    lit_val[k] = val;
  endtask

  task automatic set(logic [19:0] i, logic vv,
                     logic rr, logic tt);
    ins = i; v = vv; res = rr; tk = tt;
  endtask

  task automatic step(string nm);
    int op, d, a, b;
    bit wd, r1, r2, ctl, raw;
    logic [5:0] e;
    b0.id_instruction = ins; b0.id_valid = v;
    b0.ex_branch_resolved = res;
    b0.ex_branch_taken = tk;
    b1.id_instruction = ins; b1.id_valid = v;
    b1.ex_branch_resolved = res;
    b1.ex_branch_taken = tk;
    b2.id_instruction = ins; b2.id_valid = v;
    b2.ex_branch_resolved = res;
    b2.ex_branch_taken = tk;
    #1;
    op = int'(ins[19:16]);
    d  = int'(ins[15:12]);
    a  = int'(ins[11:8]);
    b  = int'(ins[7:4]);
    wd  = !(op == 1 || op == 10 || op == 11 ||
            op == 12 || op == 15);
    r1  = !(op == 12 || op == 15);
    r2  = (op >= 1 && op <= 11);
    ctl = (op >= 10 && op <= 12);
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 16; r++)
        nready[k][r] = ready[k][r];
      npend[k] = pend[k];
      if (reset) begin
        e = 6'b000110;
        for (int r = 0; r < 16; r++)
          nready[k][r] = 0;
        npend[k] = 1'b0;
      end else begin
        raw = v && ((r1 && cyc < ready[k][a]) ||
                    (r2 && cyc < ready[k][b]));
        if (pend[k] && res && tk) begin
          e = {5'b11011, raw};
          npend[k] = 1'b0;
        end else if (pend[k] && !res) begin
          e = {5'b00001, raw};
        end else if (raw) begin
          e = 6'b000011;
          npend[k] = 1'b0;
        end else begin
          e = {4'b1010, !v, 1'b0};
          if (v && wd)
            nready[k][d] = cyc + 1 +
              (op == 0 ? ls[k] : as[k]);
          npend[k] = v && ctl;
        end
      end
      chk($sformatf("%s_u%0d", nm, k), got(k), e);
      if (lit_en[k])
        chk($sformatf("%s_lit_u%0d", nm, k),
            got(k), lit_val[k]);
      lit_en[k] = 1'b0;
    end
    @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 16; r++)
        ready[k][r] = nready[k][r];
      pend[k] = npend[k];
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      set(mk(15, 0, 0, 0), 1'b0, 1'b0, 1'b0);
      step("idle");
    end
  endtask

  logic [19:0] cur;

  initial begin
    for (int k = 0; k < 3; k++) begin
      lit_en[k] = 1'b0;
      pend[k]   = 1'b0;
      for (int r = 0; r < 16; r++) ready[k][r] = 0;
    end
    reset = 1'b1;
    set(mk(2, 1, 2, 3), 1'b1, 1'b0, 1'b0);
    @(negedge clock);

    lit(0, 6'b000110); step("rst0");
    lit(0, 6'b000110); step("rst1");
    reset = 1'b0;
    lit(0, 6'b101000); step("indep");

    set(mk(0, 3, 0, 0), 1'b1, 1'b0, 1'b0);
    lit(0, 6'b101000); step("ld_r3");
    set(mk(2, 5, 3, 1), 1'b1, 1'b0, 1'b0);
    lit(0, 6'b000011); step("lduse_stall");
    lit(0, 6'b101000); step("lduse_go");

    idle(4);
    set(mk(2, 2, 0, 0), 1'b1, 1'b0, 1'b0);
    lit(1, 6'b101000); step("add_r2");
    set(mk(3, 4, 2, 2), 1'b1, 1'b0, 1'b0);
    lit(0, 6'b101000);
    lit(1, 6'b000011); step("sub_s1");
    lit(1, 6'b000011); step("sub_s2");
    lit(1, 6'b101000); step("sub_go");

    idle(4);
    set(mk(10, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    lit(0, 6'b101000); step("beq");
    set(mk(2, 8, 0, 0), 1'b1, 1'b0, 1'b0);
    lit(0, 6'b000010); step("br_hold");
    set(mk(2, 8, 0, 0), 1'b1, 1'b1, 1'b1);
    lit(0, 6'b110110); step("br_taken");
    set(mk(15, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    lit(0, 6'b101010); step("after_taken");

    idle(4);
    set(mk(0, 6, 0, 0), 1'b1, 1'b0, 1'b0);
    lit(0, 6'b101000);
    lit(2, 6'b101000); step("ld_r6");
    set(mk(11, 0, 0, 1), 1'b1, 1'b0, 1'b0);
    lit(0, 6'b101000);
    lit(2, 6'b101000); step("bne");
    set(mk(2, 7, 6, 1), 1'b1, 1'b1, 1'b0);
    lit(0, 6'b101000);
    lit(2, 6'b000011); step("nt_resolve");
    set(mk(2, 7, 6, 1), 1'b1, 1'b0, 1'b0);
    lit(2, 6'b000011); step("nt_extra");
    lit(2, 6'b101000); step("nt_go");

    idle(5);
    set(mk(0, 3, 0, 0), 1'b1, 1'b0, 1'b0);
    step("ld_r3b");
    set(mk(10, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    step("beq_b");
    reset = 1'b1;
    set(mk(15, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    lit(2, 6'b000110); step("mid_rst");
    reset = 1'b0;
    set(mk(2, 5, 3, 0), 1'b1, 1'b1, 1'b1);
    lit(0, 6'b101000);
    lit(2, 6'b101000); step("post_rst");

    cur = mk(15, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) >= 60)
        cur = {4'($urandom_range(0, 15)),
               4'($urandom_range(0, 7)),
               4'($urandom_range(0, 7)),
               4'($urandom_range(0, 7)),
               4'($urandom)};
      reset = ($urandom_range(0, 199) == 0);
      set(cur, $urandom_range(0, 99) < 85,
          $urandom_range(0, 99) < 30,
          1'($urandom));
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage, 20-bit pipeline (IF, ID, EX, MEM, WB).
- Sits beside the ID stage. Inspects the instruction held in IF/ID and drives the write-enable, flush and bubble controls of the PC, IF/ID and ID/EX registers.
- Tracks outstanding register writes with a 16-entry countdown scoreboard.
- Holds fetch while a branch or jump is unresolved in EX.

Parameters:
- LOAD_STALL, 1: bubbles required between a load and a dependent instruction (range 0..3).
- ALU_STALL, 0: bubbles required between an ALU op and a dependent instruction (range 0..3).
- CNT_W, 2: scoreboard counter width.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_instruction  in  20  instruction in IF/ID; opcode [19:16], dest [15:12], op1 [11:8], op2 [7:4]
- id_valid  in  1  IF/ID holds a real instruction
- ex_branch_resolved  in  1  branch/jump in EX has computed its outcome this cycle
- ex_branch_taken  in  1  outcome; qualified by ex_branch_resolved
- pc_write  out  1  PC load enable
- pc_sel  out  1  1 = load the branch target from EX; 0 = sequential PC
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID cleared to NOP/invalid
- id_ex_bubble  out  1  force NOP into ID/EX instead of the decoded instruction
- raw_stall  out  1  a RAW hazard is detected this cycle (debug/performance)

Behaviour:
- Reset is synchronous and active-high. While reset is high, outputs are forced to: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pc_sel=0, raw_stall=0.
- At the first clock edge with reset high, all scoreboard counters clear to 0 and the FSM enters RUN.
- Reset asserted mid-branch or mid-stall abandons that state; no pending state survives reset.

Decode (package function):
- writes_dest: every opcode except ST, BEQ, BNE, J, NOP.
- reads_op1: every opcode except J and NOP.
- reads_op2: ALU ops, ST, BEQ, BNE.
- is_ctrl: BEQ, BNE, J.

Scoreboard:
- cnt[r] = remaining bubbles before register r may be read in ID.
- Every cycle, each nonzero cnt decrements by 1. Stalls do not stop the decrement, because downstream stages keep moving.
- On issue of a dest-writing instruction, cnt[dest] is loaded with LOAD_STALL for LD, or ALU_STALL otherwise. The load overrides that entry's decrement in the same cycle.
- raw_stall = id_valid & ((reads_op1 & cnt[op1]!=0) | (reads_op2 & cnt[op2]!=0)).

Issue:
- Issue occurs when id_valid & !raw_stall and the FSM is in RUN (or in the not-taken resolve cycle below).

FSM states and outputs:
- RUN, no stall or issue: pc_write=1, if_id_write=1, id_ex_bubble=!id_valid.
- RUN with raw_stall: pc_write=0, if_id_write=0, id_ex_bubble=1.
- RUN with an is_ctrl instruction issuing: outputs as a normal issue, and next state is BR_PEND. The fall-through instruction enters IF/ID.
- BR_PEND, not resolved: pc_write=0, if_id_write=0, id_ex_bubble=1.
- BR_PEND, resolved and taken: pc_sel=1, pc_write=1, if_id_flush=1, id_ex_bubble=1; go to RUN.
- BR_PEND, resolved and not taken: behave exactly as RUN for this cycle (hazard check and issue of the held instruction); go to RUN, or stay in BR_PEND if that instruction is itself is_ctrl and issues.

Priority and boundary conditions:
- Priority: reset > branch resolve > raw_stall > issue.
- ex_branch_resolved outside BR_PEND is ignored.
- A raw_stall during BR_PEND is irrelevant because id_ex_bubble=1 already.
- The same register used as op1 and op2 stalls once, not twice.
- dest == op1 of the issuing instruction: the hazard check uses the pre-update cnt.
- cnt saturates at 0 and never wraps below zero.
- A LOAD_STALL value larger than 2^CNT_W - 1 is an elaboration error.

Decomposition:
- Shared package pipeline_pkg holds:
  - opcode constants: OP_LD=4'h0, OP_ST=4'h1, ALU ops 4'h2-4'h9, OP_BEQ=4'hA, OP_BNE=4'hB, OP_J=4'hC, OP_NOP=4'hF;
  - field-slice constants;
  - the FSM state enum {RUN, BR_PEND};
  - the decode functions writes_dest, reads_op1, reads_op2, is_ctrl.
- One sub-module is natural: hazard_scoreboard, which holds the 16 counters, the decrement/load logic and the raw_stall compare.

Test Plan:
- Reset: hold reset 2 cycles with id_valid=1 -> outputs at the reset values; after release, cnt all 0 and pc_write=1 on an independent instruction.
- Load-use: LD R3 then ADD R5,R3,R1 (LOAD_STALL=1) -> exactly 1 cycle of raw_stall=1, pc_write=0, id_ex_bubble=1; the ADD issues the next cycle.
- ALU back-to-back: ADD R2 then SUB R4,R2,R2 with ALU_STALL=0 -> no stall. With ALU_STALL=2 -> 2 stall cycles, and only 2, despite the double-operand match.
- Taken branch: BEQ issues; BR_PEND for 1 cycle; resolve with taken=1 -> pc_sel=1, pc_write=1, if_id_flush=1 in that cycle; the fall-through instruction never reaches ID/EX.
- Not-taken branch with hazard: LD R6, BNE, then ADD R7,R6 held in IF/ID; resolve with not-taken -> the ADD issues in the resolve cycle because cnt[R6] has already decayed to 0. Repeat with LOAD_STALL=3 -> 1 extra stall cycle after resolve.
- Reset mid-branch: assert reset while in BR_PEND with cnt[R3]=2 -> after release the state is RUN, cnt[R3]=0, and a resolve pulse is ignored.
